// File: rtl/sevenseg_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for the seven-segment frame reader: the ten legal
// segment patterns (bit order {a,b,c,d,e,f,g}, active-high), the code used
// for an unrecognised pattern, and the digit-settling FSM state type.
// ---------------------------------------------------------------------------
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Nibble written for any pattern that is not one of the ten digits
  localparam logic [3:0] INVALID_CODE = 4'hF;

  // WAIT   : no single digit strobed, nothing to settle on
  // SETTLE : one digit strobed, counting identical samples
  // HELD   : this strobe period already captured, waiting for a change
  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/sevenseg_reader_if.sv
// ---------------------------------------------------------------------------
// sevenseg_reader_if
// Bundles the multiplexed-display lines observed by the reader together with
// the decoded frame it produces.
//   seg     : segment lines {a,b,c,d,e,f,g}
//   dig_sel : one-hot digit strobe, DIGITS wide
//   bcd     : decoded frame, nibble i = digit i
//   valid   : one-cycle pulse on each completed frame
//   err     : current frame contains an unrecognised pattern
// master = display side (drives seg/dig_sel), slave = the reader.
// ---------------------------------------------------------------------------
interface sevenseg_reader_if #(
  parameter int DIGITS = 4
);

  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] bcd;
  logic                valid;
  logic                err;

  modport master (
    output seg,
    output dig_sel,
    input  bcd,
    input  valid,
    input  err
  );

  modport slave (
    input  seg,
    input  dig_sel,
    output bcd,
    output valid,
    output err
  );

endinterface

// File: rtl/sevenseg_reader_seg_to_bcd.sv
// ---------------------------------------------------------------------------
// seg_to_bcd
// Purely combinational decoder from a 7-bit segment pattern to a BCD digit.
//   seg     : pattern {a,b,c,d,e,f,g}
//   digit   : 0..9, or INVALID_CODE for an unrecognised pattern
//   invalid : high when the pattern is not one of the ten digits
// ---------------------------------------------------------------------------
module seg_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  // Anything that is not an exact digit shape is reported as invalid
  always_comb begin
    digit   = INVALID_CODE;
    invalid = 1'b1;
    case (seg)
      SEG_0: begin digit = 4'd0; invalid = 1'b0; end
      SEG_1: begin digit = 4'd1; invalid = 1'b0; end
      SEG_2: begin digit = 4'd2; invalid = 1'b0; end
      SEG_3: begin digit = 4'd3; invalid = 1'b0; end
      SEG_4: begin digit = 4'd4; invalid = 1'b0; end
      SEG_5: begin digit = 4'd5; invalid = 1'b0; end
      SEG_6: begin digit = 4'd6; invalid = 1'b0; end
      SEG_7: begin digit = 4'd7; invalid = 1'b0; end
      SEG_8: begin digit = 4'd8; invalid = 1'b0; end
      SEG_9: begin digit = 4'd9; invalid = 1'b0; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// ---------------------------------------------------------------------------
// sevenseg_reader
// Watches a multiplexed seven-segment display and reconstructs the number
// shown. Each strobed digit is accepted once its {seg,dig_sel} sample has
// been identical for STABLE_CYCLES consecutive samples; once every digit
// position has been captured the whole frame is published on bcd/err with a
// one-cycle valid pulse.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sevenseg_reader_if slave (seg, dig_sel in; bcd, valid, err out)
// STABLE_CYCLES must lie in 2..15; DIGITS must match the interface DIGITS.
// ---------------------------------------------------------------------------
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input logic              clk,
  input logic              rst,
  sevenseg_reader_if.slave bus
);

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

  // Current sample and the sample from one cycle earlier
  logic [6:0]          seg_s_q, seg_s_d;
  logic [DIGITS-1:0]   sel_s_q, sel_s_d;
  logic [6:0]          seg_p_q, seg_p_d;
  logic [DIGITS-1:0]   sel_p_q, sel_p_d;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;

  // Per-digit capture storage for the frame being assembled
  logic [4*DIGITS-1:0] nib_q, nib_d;
  logic [DIGITS-1:0]   inv_q, inv_d;
  logic [DIGITS-1:0]   mask_q, mask_d;

  // Published frame
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;

  logic [3:0]          dec_digit;
  logic                dec_invalid;
  logic                same;
  logic                onehot;
  logic                capture;

  seg_to_bcd u_dec (
    .seg     (seg_s_q),
    .digit   (dec_digit),
    .invalid (dec_invalid)
  );

  // Next-state logic: sampling, the settling FSM, per-digit capture and
  // frame completion. A capture that fills the mask publishes the frame
  // including the digit captured on that very edge, then empties the mask.
  always_comb begin
    seg_s_d = bus.seg;
    sel_s_d = bus.dig_sel;
    seg_p_d = seg_s_q;
    sel_p_d = sel_s_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    inv_d   = inv_q;
    mask_d  = mask_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    valid_d = 1'b0;
    capture = 1'b0;

    same   = (seg_s_q == seg_p_q) && (sel_s_q == sel_p_q);
    onehot = $onehot(sel_s_q);

    case (state_q)
      WAIT: begin
        if (onehot) begin
          state_d = SETTLE;
          cnt_d   = 4'd1;
        end else begin
          cnt_d   = 4'd0;
        end
      end
      SETTLE: begin
        if (!onehot) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end else if (!same) begin
          cnt_d   = 4'd1;
        end else if (cnt_q + 4'd1 == STABLE_LIM) begin
          capture = 1'b1;
          cnt_d   = STABLE_LIM;
          state_d = HELD;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      HELD: begin
        // Only a change in the display reopens the window, so a digit is
        // taken at most once per strobe period
        if (!same) begin
          if (onehot) begin
            state_d = SETTLE;
            cnt_d   = 4'd1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = WAIT;
        cnt_d   = 4'd0;
      end
    endcase

    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_s_q[i]) begin
          nib_d[4*i +: 4] = dec_digit;
          inv_d[i]        = dec_invalid;
        end
      end
      mask_d = mask_q | sel_s_q;
      if (&mask_d) begin
        bcd_d   = nib_d;
        err_d   = |inv_d;
        valid_d = 1'b1;
        mask_d  = '0;
        inv_d   = '0;
      end
    end
  end

  // All state registers; reset wins over any capture or frame completion
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s_q <= '0;
      sel_s_q <= '0;
      seg_p_q <= '0;
      sel_p_q <= '0;
      state_q <= WAIT;
      cnt_q   <= '0;
      nib_q   <= '0;
      inv_q   <= '0;
      mask_q  <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      seg_s_q <= seg_s_d;
      sel_s_q <= sel_s_d;
      seg_p_q <= seg_p_d;
      sel_p_q <= sel_p_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      inv_q   <= inv_d;
      mask_q  <= mask_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.err   = err_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_reader
// Drives a four-digit reader with directed display sequences and checks the
// published frames against a queue of hand-computed expectations (value,
// error flag and the exact cycle of the valid pulse). A second, one-digit
// reader shares digit 0 so that every digit-0 capture shows up as a pulse.
// ---------------------------------------------------------------------------
module tb_sevenseg_reader;

  localparam int TB_STABLE = 4;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PBAD = 7'b0000001;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   main_valids = 0;
  int   dut1_valids = 0;
  exp_t exp_q[$];

  sevenseg_reader_if #(.DIGITS(4)) bus ();
  sevenseg_reader_if #(.DIGITS(1)) bus1 ();

  assign bus1.seg     = bus.seg;
  assign bus1.dig_sel = bus.dig_sel[0];

  sevenseg_reader #(.STABLE_CYCLES(TB_STABLE), .DIGITS(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sevenseg_reader #(.STABLE_CYCLES(TB_STABLE), .DIGITS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Free-running clock and an edge counter used to time valid pulses
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drive one display state, then let it stand for hold cycles
  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] pat,
                               input int hold);
    bus.dig_sel = sel;
    bus.seg     = pat;
    repeat (hold) @(negedge clk);
  endtask

  // Expect a frame whose last digit is driven right now: the first edge to
  // sample it is cyc+1, and capture lands TB_STABLE edges after that
  task automatic pushExpect(input logic [15:0] b, input logic e);
    exp_t x;
    x.bcd = b;
    x.err = e;
    x.cyc = cyc + 1 + TB_STABLE;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: every valid pulse is matched against the oldest
  // expectation; an expectation whose cycle passes without a pulse fails
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid) begin
      main_valids++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_bcd", 32'(bus.bcd), 32'(e.bcd));
        checkOutput("frame_err", 32'(bus.err), 32'(e.err));
        checkOutput("frame_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      e = exp_q.pop_front();
      checkOutput("frame_missed_valid", 32'(bus.valid), 32'd1);
    end
    if (bus1.valid) dut1_valids++;
  end

  initial begin
    int m0;
    int d0;
    rst         = 1'b1;
    bus.seg     = '0;
    bus.dig_sel = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bcd", 32'(bus.bcd), 32'd0);
    checkOutput("reset_err", 32'(bus.err), 32'd0);
    checkOutput("reset_valid", 32'(bus.valid), 32'd0);
    rst = 1'b0;

    // Digits 1..3 first, then digit 0 shows '3': frame at exactly k+4
    applyStimulus(4'b0010, P2, 8);
    applyStimulus(4'b0100, P5, 8);
    applyStimulus(4'b1000, P7, 8);
    pushExpect(16'h7523, 1'b0);
    applyStimulus(4'b0001, P3, 8);

    // Plain 1,2,5,7 frame
    applyStimulus(4'b0001, P1, 8);
    applyStimulus(4'b0010, P2, 8);
    applyStimulus(4'b0100, P5, 8);
    pushExpect(16'h7521, 1'b0);
    applyStimulus(4'b1000, P7, 8);

    // Bad pattern on digit 2, then a clean frame clears err
    applyStimulus(4'b0001, P1, 8);
    applyStimulus(4'b0010, P2, 8);
    applyStimulus(4'b0100, PBAD, 8);
    pushExpect(16'h7F21, 1'b1);
    applyStimulus(4'b1000, P7, 8);
    applyStimulus(4'b0001, P1, 8);
    applyStimulus(4'b0010, P2, 8);
    applyStimulus(4'b0100, P5, 8);
    pushExpect(16'h7521, 1'b0);
    applyStimulus(4'b1000, P7, 8);

    // Digit 0 flickers every 3 cycles: never captured, so digits 1..3
    // alone must not complete a frame
    m0 = main_valids;
    d0 = dut1_valids;
    for (int t = 0; t < 8; t++) applyStimulus(4'b0001, (t % 2) ? P9 : P8, 3);
    applyStimulus(4'b0010, P4, 8);
    applyStimulus(4'b0100, P6, 8);
    applyStimulus(4'b1000, P9, 8);
    checkOutput("flicker_main_valids", 32'(main_valids - m0), 32'd0);
    checkOutput("flicker_digit0_captures", 32'(dut1_valids - d0), 32'd0);
    pushExpect(16'h9640, 1'b0);
    applyStimulus(4'b0001, P0, 8);

    // One long strobe of digit 0 is captured exactly once
    d0 = dut1_valids;
    applyStimulus(4'b0001, P6, 20);
    checkOutput("long_hold_captures", 32'(dut1_valids - d0), 32'd1);
    checkOutput("long_hold_digit", 32'(bus1.bcd), 32'h6);
    applyStimulus(4'b0010, P8, 8);
    applyStimulus(4'b0100, P0, 8);
    pushExpect(16'h3086, 1'b0);
    applyStimulus(4'b1000, P3, 8);

    // Three digits captured, then reset: the partial frame must be lost,
    // so digit 3 alone after reset cannot complete anything
    applyStimulus(4'b0001, P9, 8);
    applyStimulus(4'b0010, P9, 8);
    applyStimulus(4'b0100, P9, 6);
    rst         = 1'b1;
    bus.dig_sel = '0;
    bus.seg     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("midframe_reset_bcd", 32'(bus.bcd), 32'd0);
    checkOutput("midframe_reset_err", 32'(bus.err), 32'd0);
    applyStimulus(4'b1000, P5, 8);
    applyStimulus(4'b0001, P4, 8);
    applyStimulus(4'b0010, P3, 8);
    pushExpect(16'h5234, 1'b0);
    applyStimulus(4'b0100, P2, 8);

    // Idle: frame holds, no further pulses
    applyStimulus(4'b0000, 7'b0, 10);
    checkOutput("idle_bcd_hold", 32'(bus.bcd), 32'h5234);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_total", 32'(main_valids), 32'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_reader.md
SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples needed to accept a digit (legal range 2..15).
REQ-002 Parameter DIGITS, default 4, is the number of multiplexed digit positions per frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high, as driven onto a multiplexed display.
REQ-006 dig_sel  input  DIGITS  one-hot digit strobe; bit i high means seg currently shows digit i.
REQ-007 bcd  output  4*DIGITS  decoded frame; nibble i holds digit i.
REQ-008 valid  output  1  one-cycle pulse when bcd has just been updated with a complete frame.
REQ-009 err  output  1  high while the current bcd frame contains at least one invalid pattern; updates only with valid.

Function
REQ-010 seg and dig_sel SHALL be registered every cycle into sample registers; all decisions use the sampled values.
REQ-011 Pattern map SHALL be 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; any other pattern SHALL decode to 4'hF and be flagged invalid.
REQ-012 FSM states SHALL be WAIT, SETTLE and HELD.
REQ-013 WAIT: the sampled dig_sel is not one-hot (including all-zero); the stability counter is held at 0.
REQ-014 WAIT->SETTLE SHALL occur when the sampled dig_sel is one-hot; the counter loads 1.
REQ-015 SETTLE: the counter SHALL increment while {seg,dig_sel} equals the previous sample.
REQ-016 SETTLE: any difference SHALL reload the counter to 1, or go to WAIT if dig_sel is no longer one-hot.
REQ-017 The capture SHALL occur when the counter reaches STABLE_CYCLES; the FSM then goes to HELD.
REQ-018 Capture timing: the digit register SHALL update at edge k+STABLE_CYCLES, where k is the first edge that sampled the new value (capture at k+4 for the default).
REQ-019 HELD: no further capture SHALL occur.
REQ-020 HELD: any change in {seg,dig_sel} SHALL return the FSM to SETTLE (one-hot) or WAIT (not one-hot), so each strobe period is captured at most once.
REQ-021 A capture SHALL write the decoded nibble and invalid bit for the strobed digit and set that digit's bit in a DIGITS-bit capture mask.
REQ-022 A re-capture of a digit already in the mask SHALL overwrite it.
REQ-023 When a capture completes the mask (all ones), bcd SHALL load all nibbles, including the one being captured, at that same edge.
REQ-024 On that same edge, err SHALL load the OR of all invalid bits, valid SHALL assert for exactly one cycle, and the mask and invalid bits SHALL clear.
REQ-025 Between frames bcd and err SHALL hold their values; valid SHALL be 0.
REQ-026 A partial frame SHALL never update bcd or err.

Reset
REQ-027 On rst high at a clock edge: bcd=0, valid=0, err=0, FSM=WAIT, counter=0, mask=0, sample registers=0.
REQ-028 rst asserted mid-frame or mid-settle SHALL discard all partial captures; the first frame after reset starts from an empty mask.
REQ-029 rst SHALL take priority over every capture and frame-complete event in the same cycle.

Structure
REQ-030 Shared package sevenseg_pkg SHALL hold the ten segment pattern constants, the FSM state type, and the invalid code 4'hF.
REQ-031 One combinational sub-module, seg_to_bcd (7-bit pattern -> 4-bit digit plus invalid flag), SHALL implement REQ-011.

Verification
REQ-032 Hold dig_sel=0001, seg=1111001 from edge k -> nibble0=3 written at edge k+4; no capture at k+3.
REQ-033 Strobe digits 0..3 with 0110000, 1101101, 1011011, 1110000, each held 8 cycles -> one valid pulse, bcd=16'h7521, err=0.
REQ-034 Same as REQ-033 but digit 2 shows 0000001 -> bcd=16'h7F21, err=1; the next good frame clears err to 0.
REQ-035 Toggle seg every 3 cycles with dig_sel fixed, STABLE_CYCLES=4 -> no capture, valid never asserts.
REQ-036 Hold one pattern for 20 cycles -> exactly one capture.
REQ-037 Assert rst after 3 of 4 digits are captured, then send a full frame -> valid once, bcd reflects only the post-reset frame.
